lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store controller between the pipeline MEM stage and the byte-addressable data `memory` block. It accepts one load or store request at a time over a valid/ready handshake. It drives the memory's port-1 address, write data, byte mask and write enable, and covers the memory's one-cycle registered read latency. It returns formatted load data or a store acknowledge, with an error flag, over a second valid/ready handshake.

## Interface
- `ADDR_W`, 16, memory byte-address width; must match the attached `memory`.
- `ALLOW_MISALIGNED`, 1, 1 = misaligned halfword/word accesses go to memory unchanged; 0 = they return an error.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  controller can accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  RV32 funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; others are illegal.
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data, right-aligned.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  consumer takes the response.
- `o_rsp_rdata`  out  32  formatted load data; 0 for stores and errors.
- `o_rsp_err`  out  1  access fault: illegal funct3, out of range, or disallowed misalignment.
- `o_mem_addr`  out  ADDR_W  memory port-1 address.
- `o_mem_wdata`  out  32  memory write data.
- `o_mem_bmask`  out  4  memory byte mask.
- `o_mem_wren`  out  1  memory write enable.
- `i_mem_rdata`  in  32  memory port-1 registered read data.

## Operation
- **FSM states:** IDLE, READ, WRITE, RESP.
- **IDLE:**
  - `o_req_ready` = 1, and only in this state.
  - On `i_req_valid`, latch we, funct3, addr and wdata into the request register, then run the checks below.
- **Checks**, with size = 1, 2 or 4 bytes:
  - Illegal funct3. This includes funct3 100/101 with we = 1.
  - `addr[31:ADDR_W]` ≠ 0.
  - `addr[ADDR_W-1:0]` + size − 1 > 2^ADDR_W − 1, i.e. the access would wrap. Compute this in ADDR_W+1 bits.
  - If `ALLOW_MISALIGNED` = 0: halfword with `addr[0]` ≠ 0, or word with `addr[1:0]` ≠ 0.
  - Any failure: go to RESP with err = 1. No memory access occurs and `o_mem_wren` stays 0.
  - Otherwise go to READ for a load, or WRITE for a store.
- **READ:** `o_mem_addr` = latched address. Go to RESP next cycle.
- **WRITE:**
  - `o_mem_wren` = 1 for exactly this cycle.
  - `o_mem_wdata` = latched wdata.
  - `o_mem_bmask`: 0001 (SB), 0011 (SH), 1111 (SW). The memory applies byte lanes at addr+0..+3, so no lane shifting.
  - Go to RESP.
- **RESP:**
  - `o_rsp_valid` = 1. Hold `o_mem_addr` at the latched address so `i_mem_rdata` stays stable.
  - `o_rsp_rdata`, formatted combinationally from `i_mem_rdata`:
    - LB: sign-extend `[7:0]`.
    - LBU: zero-extend `[7:0]`.
    - LH: sign-extend `[15:0]`.
    - LHU: zero-extend `[15:0]`.
    - LW: `[31:0]`.
    - Stores and errors: 0.
  - On `i_rsp_ready`, go to IDLE.
- **Outside WRITE:** `o_mem_wren` = 0, `o_mem_bmask` = 0000, `o_mem_wdata` = 0.
- **Address in IDLE:** `o_mem_addr` = `i_req_addr[ADDR_W-1:0]`. This lets the memory read speculatively; harmless.

## Timing
- **Reset:** state IDLE, request register cleared.
  - Outputs: `o_rsp_valid` 0, `o_rsp_err` 0, `o_rsp_rdata` 0, `o_mem_wren` 0, `o_mem_bmask` 0, `o_mem_wdata` 0.
  - `o_req_ready` 1 in the cycle after reset deasserts.
- **Request accept:** an edge with `i_req_valid` & `o_req_ready`, at cycle T.
- **Load:** READ at T+1 (memory registers data at the end of T+1); `o_rsp_valid` from T+2.
- **Store:** WRITE at T+1 (memory writes at the end of T+1); `o_rsp_valid` from T+2.
- **Error:** `o_rsp_valid` from T+1.
- **Response hold:** held indefinitely while `i_rsp_ready` = 0, with data and err stable.
- **Throughput:** the response handshake at cycle R returns to IDLE. The next request can be accepted at R+1; no same-cycle reaccept.
- **Reset mid-operation:** `i_reset` in any state goes to IDLE next edge. `o_mem_wren` is low from that cycle on and no pending response is emitted.
  - A reset asserted during WRITE does not suppress that cycle's edge-write; this is documented.
- **Ignored inputs:** request fields are ignored outside IDLE. `i_rsp_ready` is ignored outside RESP.

## Structure
- **Shared package `lsu_pkg`:**
  - FSM state enum.
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - Function `size_of(funct3)`.
- **Sub-module `lsu_load_fmt`:** combinational, (funct3, rdata) → formatted data. It is reused by the forwarding path later.
- **Address arithmetic:** the range-check adder uses the codebase's `addsub32` adder, consistent with the other datapath blocks.

## Test plan
- **Aligned word:** SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010 → store ack at T+2 with err 0; load `o_rsp_rdata` 0xDEADBEEF at T+2.
- **Byte/half sign handling:** mem[0x20..0x23] = 0x80,0xFF,0x34,0x12.
  - LB 0x20 → 0xFFFFFF80.
  - LBU 0x20 → 0x00000080.
  - LH 0x20 → 0xFFFFFF80.
  - LHU 0x22 → 0x00001234.
- **Misaligned:** SW 0x0101 data 0x11223344.
  - `ALLOW_MISALIGNED` = 1: LW 0x0101 → 0x11223344.
  - `ALLOW_MISALIGNED` = 0: err = 1 at T+1, wren never asserted, memory unchanged.
- **Range/wrap:** LW 0xFFFE → err = 1 (wrap). LB 0x0001_0000 → err = 1. LB 0xFFFF → ok. funct3 011 → err = 1.
- **Backpressure:** hold `i_rsp_ready` = 0 for 5 cycles after an LW response → valid/data stable and `o_req_ready` = 0 throughout. Release → IDLE next cycle.
- **Reset mid-op:** assert `i_reset` during READ → next cycle `o_rsp_valid` = 0, `o_req_ready` = 1 after deassert, no spurious response.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      F3_W:        size = 3'd4;
      default:     size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/addsub32.sv
// 32-bit adder/subtractor shared by the datapath blocks.
module addsub32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] sum_o
);

  // Two's-complement subtract: invert b and inject the carry.
  always_comb begin
    sum_o = a_i + (b_i ^ {32{sub_i}}) + {31'd0, sub_i};
  end

endmodule

// File: rtl/lsu_load_fmt.sv
// Load data formatter: extracts and extends the addressed byte/halfword/word.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  // Select and sign/zero-extend by funct3; illegal encodings give zero.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      F3_BU:   data_o = {24'd0, rdata_i[7:0]};
      F3_H:    data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      F3_HU:   data_o = {16'd0, rdata_i[15:0]};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and the data memory port 1.
// One request in flight; covers the memory's one-cycle registered read.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W           = 16,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [2:0]  req_size;
  logic [2:0]  req_size_m1;
  logic [31:0] end_addr;
  logic        bad_f3, out_of_range, wraps, misaligned, req_bad;
  logic [31:0] fmt_data;
  logic        unused_end;

  // Request checks, evaluated on the live request while idle.
  always_comb begin
    req_size     = size_of(i_req_funct3);
    req_size_m1  = (req_size == 3'd0) ? 3'd0 : req_size - 3'd1;
    bad_f3       = (req_size == 3'd0) ||
                   (i_req_we && ((i_req_funct3 == F3_BU) || (i_req_funct3 == F3_HU)));
    out_of_range = |i_req_addr[31:ADDR_W];
    // The last byte lands past the top of memory iff any bit above ADDR_W-1 is set.
    wraps        = |end_addr[31:ADDR_W];
    misaligned   = (ALLOW_MISALIGNED == 0) &&
                   (((req_size == 3'd2) && i_req_addr[0]) ||
                    ((req_size == 3'd4) && (|i_req_addr[1:0])));
    req_bad      = bad_f3 || out_of_range || wraps || misaligned;
  end

  addsub32 u_range_add (
    .a_i   ({{(32 - ADDR_W){1'b0}}, i_req_addr[ADDR_W-1:0]}),
    .b_i   ({29'd0, req_size_m1}),
    .sub_i (1'b0),
    .sum_o (end_addr)
  );

  assign unused_end = ^end_addr[ADDR_W-1:0];

  // Next-state and request register capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          f3_d    = i_req_funct3;
          addr_d  = i_req_addr[ADDR_W-1:0];
          wdata_d = i_req_wdata;
          err_d   = req_bad;
          if (req_bad)       state_d = StResp;
          else if (i_req_we) state_d = StWrite;
          else               state_d = StRead;
        end
      end
      StRead:  state_d = StResp;
      StWrite: state_d = StResp;
      StResp:  if (i_rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request register, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  lsu_load_fmt u_load_fmt (
    .funct3_i (f3_q),
    .rdata_i  (i_mem_rdata),
    .data_o   (fmt_data)
  );

  // Outputs decoded from the registered state.
  always_comb begin
    o_req_ready = (state_q == StIdle);
    o_rsp_valid = (state_q == StResp);
    o_rsp_err   = (state_q == StResp) && err_q;
    o_rsp_rdata = ((state_q == StResp) && !we_q && !err_q) ? fmt_data : 32'd0;
    // Idle address follows the live request so the memory can read ahead.
    o_mem_addr  = (state_q == StIdle) ? i_req_addr[ADDR_W-1:0] : addr_q;
    o_mem_wren  = (state_q == StWrite);
    o_mem_wdata = (state_q == StWrite) ? wdata_q : 32'd0;
    o_mem_bmask = 4'b0000;
    if (state_q == StWrite) begin
      case (f3_q)
        F3_B:    o_mem_bmask = 4'b0001;
        F3_H:    o_mem_bmask = 4'b0011;
        F3_W:    o_mem_bmask = 4'b1111;
        default: o_mem_bmask = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a byte-addressable memory model.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Instance A: misaligned allowed.
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_f3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [15:0] a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_bmask;
  logic        a_mem_wren;

  // Instance B: misaligned rejected.
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_f3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [15:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_bmask;
  logic        b_mem_wren;
  logic        b_wren_seen;

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  lsu_mem_ctrl #(.ADDR_W(16), .ALLOW_MISALIGNED(1)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (a_req_valid),
    .o_req_ready  (a_req_ready),
    .i_req_we     (a_req_we),
    .i_req_funct3 (a_req_f3),
    .i_req_addr   (a_req_addr),
    .i_req_wdata  (a_req_wdata),
    .o_rsp_valid  (a_rsp_valid),
    .i_rsp_ready  (a_rsp_ready),
    .o_rsp_rdata  (a_rsp_rdata),
    .o_rsp_err    (a_rsp_err),
    .o_mem_addr   (a_mem_addr),
    .o_mem_wdata  (a_mem_wdata),
    .o_mem_bmask  (a_mem_bmask),
    .o_mem_wren   (a_mem_wren),
    .i_mem_rdata  (a_mem_rdata)
  );

  lsu_mem_ctrl #(.ADDR_W(16), .ALLOW_MISALIGNED(0)) dut_strict (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (b_req_valid),
    .o_req_ready  (b_req_ready),
    .i_req_we     (b_req_we),
    .i_req_funct3 (b_req_f3),
    .i_req_addr   (b_req_addr),
    .i_req_wdata  (b_req_wdata),
    .o_rsp_valid  (b_rsp_valid),
    .i_rsp_ready  (b_rsp_ready),
    .o_rsp_rdata  (b_rsp_rdata),
    .o_rsp_err    (b_rsp_err),
    .o_mem_addr   (b_mem_addr),
    .o_mem_wdata  (b_mem_wdata),
    .o_mem_bmask  (b_mem_bmask),
    .o_mem_wren   (b_mem_wren),
    .i_mem_rdata  (b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: registered read of addr+0..+3 (old data), masked byte writes.
  always @(posedge clk) begin
    a_mem_rdata <= {mem_a[a_mem_addr + 16'd3], mem_a[a_mem_addr + 16'd2],
                    mem_a[a_mem_addr + 16'd1], mem_a[a_mem_addr]};
    b_mem_rdata <= {mem_b[b_mem_addr + 16'd3], mem_b[b_mem_addr + 16'd2],
                    mem_b[b_mem_addr + 16'd1], mem_b[b_mem_addr]};
    for (int k = 0; k < 4; k++) begin
      if (a_mem_wren && a_mem_bmask[k]) mem_a[a_mem_addr + 16'(k)] = a_mem_wdata[8*k +: 8];
      if (b_mem_wren && b_mem_bmask[k]) mem_b[b_mem_addr + 16'(k)] = b_mem_wdata[8*k +: 8];
    end
    if (b_mem_wren) b_wren_seen = 1'b1;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: latency, stability under backpressure, data/err at handshake.
  logic        in_rsp = 1'b0;
  logic        ready_next = 1'b0;
  logic [31:0] held_d;
  logic        held_e;
  always @(negedge clk) begin
    if (ready_next) begin
      chk("idle_after_rsp", {30'd0, a_req_ready, a_rsp_valid}, 32'd2);
      ready_next = 1'b0;
    end
    if (a_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {31'd0, a_rsp_valid}, 32'd0);
      end else begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
          held_d = a_rsp_rdata;
          held_e = a_rsp_err;
        end else begin
          chk("hold_rdata", a_rsp_rdata, held_d);
          chk("hold_err", {31'd0, a_rsp_err}, {31'd0, held_e});
        end
        chk("req_ready_in_rsp", {31'd0, a_req_ready}, 32'd0);
        if (a_rsp_ready) begin
          chk("rsp_rdata", a_rsp_rdata, sb[0].rdata);
          chk("rsp_err", {31'd0, a_rsp_err}, {31'd0, sb[0].err});
          void'(sb.pop_front());
          in_rsp = 1'b0;
          ready_next = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e);
    int n = 0;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_f3    = f3;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      a_req_valid = 1'b0;
      return;
    end
    sb.push_back('{rdata: exp_d, err: exp_e, acc: cyc, lat: (exp_e ? 1 : 2)});
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_f3 = 3'd0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_f3 = 3'd0; b_req_addr = '0; b_req_wdata = '0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    b_wren_seen = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'hA5;
    end
    mem_a[16'h0020] = 8'h80; mem_a[16'h0021] = 8'hFF;
    mem_a[16'h0022] = 8'h34; mem_a[16'h0023] = 8'h12;
    mem_a[16'hFFFC] = 8'h01; mem_a[16'hFFFD] = 8'h02;
    mem_a[16'hFFFE] = 8'h03; mem_a[16'hFFFF] = 8'h7F;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_wren_bmask", {27'd0, a_mem_wren, a_mem_bmask}, 32'd0);
    chk("rst_wdata", a_mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);

    send(1'b1, F3_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    send(1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    send(1'b0, F3_B,  32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0);
    send(1'b0, F3_BU, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0);
    send(1'b0, F3_H,  32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0);
    send(1'b0, F3_HU, 32'h0000_0022, 32'h0,         32'h0000_1234, 1'b0);
    send(1'b1, F3_W,  32'h0000_0101, 32'h1122_3344, 32'h0000_0000, 1'b0);
    send(1'b0, F3_W,  32'h0000_0101, 32'h0,         32'h1122_3344, 1'b0);
    send(1'b0, F3_W,  32'h0000_FFFE, 32'h0,         32'h0000_0000, 1'b1);
    send(1'b0, F3_B,  32'h0001_0000, 32'h0,         32'h0000_0000, 1'b1);
    send(1'b0, F3_B,  32'h0000_FFFF, 32'h0,         32'h0000_007F, 1'b0);
    send(1'b0, F3_W,  32'h0000_FFFC, 32'h0,         32'h7F03_0201, 1'b0);
    send(1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1);
    send(1'b1, F3_BU, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1);
    send(1'b1, F3_B,  32'h0000_0030, 32'h1234_5678, 32'h0000_0000, 1'b0);
    send(1'b0, F3_W,  32'h0000_0030, 32'h0,         32'h0000_0078, 1'b0);
    send(1'b1, F3_H,  32'h0000_0034, 32'hAABB_CCDD, 32'h0000_0000, 1'b0);
    send(1'b0, F3_W,  32'h0000_0034, 32'h0,         32'h0000_CCDD, 1'b0);
    drain();

    // Backpressure: hold the LW response for 5 cycles.
    @(posedge clk); #1 a_rsp_ready = 1'b0;
    @(negedge clk);
    send(1'b0, F3_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", {31'd0, a_rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", {31'd0, a_rsp_valid}, 32'd1);
    @(posedge clk); #1 a_rsp_ready = 1'b1;
    @(negedge clk);
    drain();

    // Reset during READ: no response may follow.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_f3 = F3_W; a_req_addr = 32'h10;
    chk("rmo_ready", {31'd0, a_req_ready}, 32'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmo_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rmo_wren", {31'd0, a_mem_wren}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmo_ready_after", {31'd0, a_req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rmo_no_rsp", {31'd0, a_rsp_valid}, 32'd0);

    // Strict instance: misaligned SW rejected at T+1, no write.
    b_wren_seen = 1'b0;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_f3 = F3_W;
    b_req_addr = 32'h0000_0101; b_req_wdata = 32'h1122_3344;
    chk("strict_ready", {31'd0, b_req_ready}, 32'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("strict_mis_valid_err", {30'd0, b_rsp_valid, b_rsp_err}, 32'd3);
    chk("strict_mis_rdata", b_rsp_rdata, 32'd0);
    @(negedge clk);
    chk("strict_idle", {30'd0, b_req_ready, b_rsp_valid}, 32'd2);
    chk("strict_no_wren", {31'd0, b_wren_seen}, 32'd0);
    chk("strict_mem_same", {mem_b[16'h0104], mem_b[16'h0103], mem_b[16'h0102], mem_b[16'h0101]},
        32'hA5A5_A5A5);
    // Aligned SW still goes through.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_f3 = F3_W;
    b_req_addr = 32'h0000_0104; b_req_wdata = 32'h5566_7788;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("strict_al_write", {27'd0, b_mem_wren, b_mem_bmask}, 32'h1F);
    @(negedge clk);
    chk("strict_al_rsp", {30'd0, b_rsp_valid, b_rsp_err}, 32'd2);
    @(negedge clk);
    chk("strict_al_mem", {mem_b[16'h0107], mem_b[16'h0106], mem_b[16'h0105], mem_b[16'h0104]},
        32'h5566_7788);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
